// File: rtl/carry_save_adder.sv
// Registered 3:2 carry-save compressor with resolved three-operand total.
// Carry vector is left unshifted; bit i of carry carries weight 2^(i+1).
module carry_save_adder #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [WIDTH+1:0] total
);

   logic [WIDTH-1:0] fa_s;
   logic [WIDTH-1:0] fa_k;
   logic [WIDTH+1:0] fa_t;

   // Bank of independent full adders, one per bit position.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign fa_s[i] = a[i] ^ b[i] ^ c[i];
      assign fa_k[i] = (a[i] & b[i])
                     | (a[i] & c[i])
                     | (b[i] & c[i]);
   end

   // Resolve sum + (carry << 1); WIDTH+2 bits cannot overflow.
   always_comb begin
      fa_t = {2'b00, fa_s} + {1'b0, fa_k, 1'b0};
   end

   // Single output register stage; reset wins, idle cycles hold data.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         carry     <= '0;
         total     <= '0;
      end else if (in_valid) begin
         out_valid <= 1'b1;
         sum       <= fa_s;
         carry     <= fa_k;
         total     <= fa_t;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_carry_save_adder.sv
// Scoreboard bench for carry_save_adder: arithmetic reference model,
// expected results queued at stimulus time and checked by a monitor.
module tb_carry_save_adder;

   localparam int W = 13;
   localparam int MAXV = (1 << W) - 1;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [W-1:0] a, b, c;
   logic         out_valid;
   logic [W-1:0] sum, carry;
   logic [W+1:0] total;

   typedef struct {
      logic         v;
      logic [W-1:0] s;
      logic [W-1:0] k;
      logic [W+1:0] t;
   } exp_t;

   exp_t exp_q[$];

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] m_s;
   logic [W-1:0] m_k;
   logic [W+1:0] m_t;

   carry_save_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (out_valid),
      .sum       (sum),
      .carry     (carry),
      .total     (total)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act,
                        input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, req, $time);
      end
   endtask

   // Drive one edge's worth of stimulus and queue the expected result.
   task automatic step(input logic r, input logic v,
                       input int xa, input int xb, input int xc);
      exp_t e;
      int tot, xs;
      @(negedge clk);
      rst_n    = r;
      in_valid = v;
      a        = W'(xa);
      b        = W'(xb);
      c        = W'(xc);
      if (!r) begin
         m_s = '0;
         m_k = '0;
         m_t = '0;
         e.v = 1'b0;
      end else if (v) begin
         tot = xa + xb + xc;
         xs  = xa ^ xb ^ xc;
         m_s = W'(xs);
         m_k = W'((tot - xs) / 2);
         m_t = (W + 2)'(tot);
         e.v = 1'b1;
      end else begin
         e.v = 1'b0;
      end
      e.s = m_s;
      e.k = m_k;
      e.t = m_t;
      exp_q.push_back(e);
   endtask

   // Monitor: compare DUT outputs after every edge with a queued result.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_valid", out_valid, e.v);
            check("sum", sum, e.s);
            check("carry", carry, e.k);
            check("total", total, e.t);
            check("total_vs_csa", total,
                  longint'(sum) + 2 * longint'(carry));
         end
      end
   end

   initial begin
      int ra, rb, rc;
      m_s = '0;
      m_k = '0;
      m_t = '0;
      rst_n = 1'b0;
      in_valid = 1'b0;
      a = '0;
      b = '0;
      c = '0;

      step(0, 1, MAXV, MAXV, MAXV);
      step(0, 1, MAXV, MAXV, MAXV);

      step(1, 1, 5, 3, 6);

      for (int i = 0; i < 16; i++)
         for (int j = 0; j < 16; j++)
            for (int k = 0; k < 16; k++)
               step(1, 1, i, j, k);

      step(1, 1, MAXV, MAXV, MAXV);

      step(1, 1, 1, 2, 4);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);

      for (int i = 0; i < 60; i++) begin
         ra = int'($urandom_range(MAXV, 0));
         rb = int'($urandom_range(MAXV, 0));
         rc = int'($urandom_range(MAXV, 0));
         if (i == 30)
            step(0, 1, ra, rb, rc);
         else
            step(1, ($urandom_range(3, 0) != 0), ra, rb, rc);
      end

      step(1, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
